// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W         = 14;
    localparam int DATA_W         = 8;
    localparam int RES_W          = 16;
    localparam int CNT_W          = 8;
    localparam int TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    // Round-robin pointer update: after serving a port, favour the other one.
    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory-side and status signals of the memory arbiter.
// slave = arbiter view, master = environment view.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              p0_load;
    logic              p0_store;
    logic [ADDR_W-1:0] p0_addr;
    logic [RES_W-1:0]  p0_wdata;
    logic              p0_done;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_load;
    logic              p1_store;
    logic [ADDR_W-1:0] p1_addr;
    logic [RES_W-1:0]  p1_wdata;
    logic              p1_done;
    logic [DATA_W-1:0] p1_rdata;

    logic              mem_load;
    logic              mem_store;
    logic [ADDR_W-1:0] mem_addr;
    logic [RES_W-1:0]  mem_wdata;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;

    logic              grant;
    logic              timeout;

    modport slave (
        input  p0_load, p0_store, p0_addr, p0_wdata,
        input  p1_load, p1_store, p1_addr, p1_wdata,
        input  mem_done, mem_rdata,
        output p0_done, p0_rdata, p1_done, p1_rdata,
        output mem_load, mem_store, mem_addr, mem_wdata,
        output grant, timeout
    );

    modport master (
        output p0_load, p0_store, p0_addr, p0_wdata,
        output p1_load, p1_store, p1_addr, p1_wdata,
        output mem_done, mem_rdata,
        input  p0_done, p0_rdata, p1_done, p1_rdata,
        input  mem_load, mem_store, mem_addr, mem_wdata,
        input  grant, timeout
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin selector: a lone requester always wins,
// a tie is broken by the pointer. Purely combinational, one-hot out.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // Pick one requester, using the pointer only when both are asking.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: grants one requester at a time, holds its
// op/addr/data towards the memory unit until mem_done or a watchdog
// abort, then pulses the requester's done for one RELEASE cycle.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);

    arb_state_e        state_r;
    logic              ptr_r;
    logic              grant_r;
    logic              mem_load_r;
    logic              mem_store_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [RES_W-1:0]  mem_wdata_r;
    logic              p0_done_r;
    logic              p1_done_r;
    logic [DATA_W-1:0] p0_rdata_r;
    logic [DATA_W-1:0] p1_rdata_r;
    logic              timeout_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [1:0]        req_s;
    logic [1:0]        gnt_s;
    logic              sel_port_s;
    logic              sel_store_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [RES_W-1:0]  sel_wdata_s;
    logic              timeout_hit_s;

    assign req_s = {bus.p1_load | bus.p1_store, bus.p0_load | bus.p0_store};

    rr_arbiter2 u_rr (
        .req (req_s),
        .ptr (ptr_r),
        .gnt (gnt_s)
    );

    // Route the winning port's request fields; store wins over load.
    always_comb begin
        sel_port_s = gnt_s[1];
        if (gnt_s[1]) begin
            sel_store_s = bus.p1_store;
            sel_addr_s  = bus.p1_addr;
            sel_wdata_s = bus.p1_wdata;
        end else begin
            sel_store_s = bus.p0_store;
            sel_addr_s  = bus.p0_addr;
            sel_wdata_s = bus.p0_wdata;
        end
    end

    // The counter is 0 in the first BUSY cycle, so reaching this value means
    // the 255th BUSY cycle is ending without mem_done.
    assign timeout_hit_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            ptr_r       <= 1'b0;
            grant_r     <= 1'b0;
            mem_load_r  <= 1'b0;
            mem_store_r <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            p0_done_r   <= 1'b0;
            p1_done_r   <= 1'b0;
            p0_rdata_r  <= '0;
            p1_rdata_r  <= '0;
            timeout_r   <= 1'b0;
            cnt_r       <= '0;
        end else begin
            p0_done_r <= 1'b0;
            p1_done_r <= 1'b0;
            timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (gnt_s != 2'b00) begin
                        state_r     <= BUSY;
                        grant_r     <= sel_port_s;
                        mem_load_r  <= ~sel_store_s;
                        mem_store_r <= sel_store_s;
                        mem_addr_r  <= sel_addr_s;
                        mem_wdata_r <= sel_wdata_s;
                        cnt_r       <= '0;
                    end
                end
                BUSY: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    // mem_done takes priority over a coincident watchdog expiry.
                    if (bus.mem_done || timeout_hit_s) begin
                        state_r     <= RELEASE;
                        mem_load_r  <= 1'b0;
                        mem_store_r <= 1'b0;
                        ptr_r       <= other_port(grant_r);
                        if (grant_r) begin
                            p1_done_r <= 1'b1;
                        end else begin
                            p0_done_r <= 1'b1;
                        end
                        if (!bus.mem_done) begin
                            timeout_r <= 1'b1;
                        end else if (mem_load_r && grant_r) begin
                            p1_rdata_r <= bus.mem_rdata;
                        end else if (mem_load_r) begin
                            p0_rdata_r <= bus.mem_rdata;
                        end
                    end
                end
                RELEASE: state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.mem_load  = mem_load_r;
    assign bus.mem_store = mem_store_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.p0_done   = p0_done_r;
    assign bus.p1_done   = p1_done_r;
    assign bus.p0_rdata  = p0_rdata_r;
    assign bus.p1_rdata  = p1_rdata_r;
    assign bus.grant     = grant_r;
    assign bus.timeout   = timeout_r;

endmodule
